fetch_bundle_queue: RTL and testbench
=====================================

// Module: fetch_bundle_queue
// PURPOSE
//  Fetch stage between main_memory and instruction_fetch. Owns the fetch PC and issues bundle reads.
//  Buffers returned bundles, each with its PC, in a small FIFO.
//  Presents one bundle per cycle to the slot splitter (IXU1/IXU2/LSU/BRANCH).
//  Absorbs hazard stalls and flushes on a taken branch.
// PARAMETERS
//  INST_W    32     width of one instruction slot
//  SLOTS     4      slots per bundle (bundle = SLOTS*INST_W bits)
//  PC_W      32     fetch address width, byte addressed
//  DEPTH     4      FIFO entries, >=2, power of two
//  RESET_PC  '0     fetch PC after reset
// PORTS
//  clk            in   1              clock
//  rst            in   1              reset, asynchronous, active-low
//  mem_req        out  1              bundle read request to memory
//  mem_pc         out  PC_W           read address (current fetch PC)
//  mem_rsp_valid  in   1              bundle returned, exactly 1 cycle after mem_req
//  mem_bundle     in   SLOTS*INST_W   returned bundle
//  stall          in   1              hazard stall; consumer does not accept
//  redirect       in   1              taken branch / squash
//  redirect_pc    in   PC_W           branch target
//  out_valid      out  1              bundle available to decode
//  out_bundle     out  SLOTS*INST_W   head bundle
//  out_pc         out  PC_W           PC of head bundle
//  occupancy      out  $clog2(DEPTH+1)  valid FIFO entries
// BEHAVIOUR
//  Reset (rst=0, async):
//   - fetch_pc=RESET_PC, FIFO empty, inflight=0.
//   - mem_req=0, out_valid=0, occupancy=0, out_bundle/out_pc=0.
//  Request:
//   - mem_req = rst & ~redirect & (occupancy + inflight < DEPTH).
//   - inflight <= mem_req (1-cycle memory latency).
//   - Each issued req advances fetch_pc by SLOTS*INST_W/8 (16 at defaults), modulo 2^PC_W (wraps).
//  Response:
//   - mem_rsp_valid & ~redirect -> push {mem_bundle, pc of that req}.
//   - The request PC is kept in a 1-deep register alongside inflight.
//   - mem_rsp_valid without inflight=1 is ignored.
//  Dequeue:
//   - out_valid = ~empty & ~redirect. Pop when out_valid & ~stall.
//   - Head is registered. Minimum latency req->out_valid is 2 cycles. No bypass.
//  Push and pop in the same cycle:
//   - Both occur; occupancy unchanged.
//   - Legal when full, because credit accounting guarantees no push to a full FIFO without a pop.
//  Throughput: 1 bundle/cycle sustained with stall=0 for DEPTH>=2.
//  Redirect (highest priority):
//   - In cycle t: FIFO cleared at end of t, response arriving in t dropped, no req in t, out_valid=0 in t.
//   - fetch_pc<=redirect_pc, inflight<=0.
//   - First req at redirect_pc in t+1.
//  Redirect with stall in the same cycle: redirect wins; stall has no effect on the flush.
//  Back-to-back redirects: the last one wins; no request is issued during a redirect cycle.
//  Reset mid-transfer: in-flight response is discarded; no push after reset deasserts until a new req.
// STRUCTURE
//  - vliw_pkg holds INST_W, SLOTS, BUNDLE_W, PC_STEP and bundle_t (packed array [SLOTS] of inst).
//  - vliw_pkg holds slot index constants SLOT_IXU1=0, SLOT_IXU2=1, SLOT_LSU=2, SLOT_BR=3.
//  - Sub-module bundle_fifo: parametric sync FIFO (DEPTH x {bundle,pc}) with flush, push, pop, count.
//    Pointer width is $clog2(DEPTH)+1; pointers wrap naturally.
//  - Top holds fetch_pc, inflight, inflight_pc and request/credit logic.
// TESTING
//  1 Reset: hold rst=0 with mem_rsp_valid=1 -> mem_req=0, out_valid=0, occupancy=0.
//    Release -> mem_req=1, mem_pc=0 next cycle.
//  2 Streaming: stall=0, memory returns bundle=pc -> out_pc sequence 0,16,32,...
//    out_valid from cycle 2 after first req, continuous, occupancy<=2.
//  3 Fill/stall: stall=1 for 10 cycles -> occupancy saturates at 4, mem_req=0 once credits are exhausted.
//    Release stall -> 4 bundles drain in PC order 0..48, then 64 follows with no gap or duplicate.
//  4 Redirect with inflight: redirect=1, redirect_pc=0x200, while rsp for 0x40 arrives -> 0x40 never output.
//    FIFO empty, mem_pc=0x200 next cycle, first out_pc=0x200.
//  5 Redirect with stall=1 and FIFO full: FIFO flushed, occupancy=0 next cycle.
//    No output until the 0x... target bundle arrives.
//  6 Wrap: RESET_PC=32'hFFFF_FFF0 -> out_pc FFFF_FFF0, then 0000_0000.

Source files
------------

// File: rtl/fetch_bundle_queue_pkg.sv
// Shared constants and types for the fetch stage: bundle geometry, slot indices, PC stepping.
package fetch_bundle_queue_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned SLOTS    = 4;
  localparam int unsigned BUNDLE_W = INST_W * SLOTS;
  localparam int unsigned PC_W     = 32;
  localparam int unsigned PC_STEP  = BUNDLE_W / 8;
  localparam int unsigned DEPTH    = 4;

  localparam int unsigned SLOT_IXU1 = 0;
  localparam int unsigned SLOT_IXU2 = 1;
  localparam int unsigned SLOT_LSU  = 2;
  localparam int unsigned SLOT_BR   = 3;

  typedef logic [INST_W-1:0] inst_t;
  typedef inst_t [SLOTS-1:0] bundle_t;

  // Byte distance between consecutive bundles.
  function automatic int unsigned pc_step(input int unsigned inst_w, input int unsigned slots);
    return (inst_w * slots) / 8;
  endfunction

endpackage

// File: rtl/fetch_bundle_queue_fifo.sv
// Synchronous FIFO of {pc, bundle} entries with flush; extra pointer bit separates full from empty.
module fetch_bundle_queue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 160
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_data,
  input  logic                       i_pop,
  output logic [DW-1:0]              o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_bundle_queue.sv
// Fetch stage: owns the fetch PC, issues credit-limited bundle reads and queues returned bundles.
module fetch_bundle_queue
  import fetch_bundle_queue_pkg::*;
#(
  parameter int unsigned     INST_W   = fetch_bundle_queue_pkg::INST_W,
  parameter int unsigned     SLOTS    = fetch_bundle_queue_pkg::SLOTS,
  parameter int unsigned     PC_W     = fetch_bundle_queue_pkg::PC_W,
  parameter int unsigned     DEPTH    = fetch_bundle_queue_pkg::DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  output logic                       o_mem_req,
  output logic [PC_W-1:0]            o_mem_pc,
  input  logic                       i_mem_rsp_valid,
  input  logic [SLOTS*INST_W-1:0]    i_mem_bundle,
  input  logic                       i_stall,
  input  logic                       i_redirect,
  input  logic [PC_W-1:0]            i_redirect_pc,
  output logic                       o_out_valid,
  output logic [SLOTS*INST_W-1:0]    o_out_bundle,
  output logic [PC_W-1:0]            o_out_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_occupancy
);

  localparam int unsigned     BW   = SLOTS * INST_W;
  localparam int unsigned     CW   = $clog2(DEPTH + 1);
  localparam logic [PC_W-1:0] STEP = PC_W'(pc_step(INST_W, SLOTS));

  logic [PC_W-1:0]    r_fetch_pc;
  logic               r_inflight;
  logic [PC_W-1:0]    r_inflight_pc;
  logic [CW:0]        w_used;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic [PC_W+BW-1:0] w_head;

  // Entries held plus the one possibly in flight must leave room for its response.
  assign w_used    = {1'b0, o_occupancy} + (CW+1)'(r_inflight);
  assign o_mem_req = i_rst_n & ~i_redirect & (w_used < (CW+1)'(DEPTH));
  assign o_mem_pc  = r_fetch_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (i_redirect) begin
      r_fetch_pc <= i_redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= o_mem_req;
      if (o_mem_req) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + STEP;
      end
    end
  end

  assign w_push      = i_mem_rsp_valid & r_inflight & ~i_redirect;
  assign o_out_valid = ~w_empty & ~i_redirect;
  assign w_pop       = o_out_valid & ~i_stall;

  fetch_bundle_queue_fifo #(
    .DEPTH (DEPTH),
    .DW    (PC_W + BW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect),
    .i_push  (w_push),
    .i_data  ({r_inflight_pc, i_mem_bundle}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (o_occupancy)
  );

  assign o_out_pc     = w_head[BW +: PC_W];
  assign o_out_bundle = w_head[BW-1:0];

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Bench for fetch_bundle_queue: directed vector table, randomized run against a queue model, PC wrap.
module tb_fetch_bundle_queue;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        stall    = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] rpc      = '0;
  logic        spur     = 1'b0;

  logic         req1, ov1, req2, ov2;
  logic [31:0]  mpc1, opc1, mpc2, opc2;
  logic [127:0] ob1, ob2;
  logic [2:0]   occ1, occ2;

  // Memory models: answer exactly one cycle after each request.
  logic        prev1_req = 1'b0, prev2_req = 1'b0;
  logic [31:0] prev1_pc  = '0,   prev2_pc  = '0;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [127:0] bnd(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_A5A5, pc + 32'd3, ~pc, pc};
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) begin
    prev1_req <= req1;
    prev1_pc  <= mpc1;
    prev2_req <= req2;
    prev2_pc  <= mpc2;
  end

  fetch_bundle_queue u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .o_mem_req       (req1),
    .o_mem_pc        (mpc1),
    .i_mem_rsp_valid (prev1_req | spur),
    .i_mem_bundle    (bnd(prev1_pc)),
    .i_stall         (stall),
    .i_redirect      (redirect),
    .i_redirect_pc   (rpc),
    .o_out_valid     (ov1),
    .o_out_bundle    (ob1),
    .o_out_pc        (opc1),
    .o_occupancy     (occ1)
  );

  fetch_bundle_queue #(
    .RESET_PC (32'hFFFF_FFF0)
  ) u_dut_wrap (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .o_mem_req       (req2),
    .o_mem_pc        (mpc2),
    .i_mem_rsp_valid (prev2_req | spur),
    .i_mem_bundle    (bnd(prev2_pc)),
    .i_stall         (stall),
    .i_redirect      (redirect),
    .i_redirect_pc   (rpc),
    .o_out_valid     (ov2),
    .o_out_bundle    (ob2),
    .o_out_pc        (opc2),
    .o_occupancy     (occ2)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic        spur;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_mpc;
    logic        e_ov;
    logic [31:0] e_opc;
    int          e_occ;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, s, rd, sp, input logic [31:0] p, input logic q,
                     input logic [31:0] mp, input logic v, input logic [31:0] op, input int oc);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = rd; t.spur = sp; t.rpc = p;
    t.e_req = q; t.e_mpc = mp; t.e_ov = v; t.e_opc = op; t.e_occ = oc;
    tbl.push_back(t);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, s, rd, sp, input logic [31:0] p);
    @(negedge clk);
    rst_n = r; stall = s; redirect = rd; spur = sp; rpc = p;
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  logic [31:0] mq[$];
  logic [31:0] m_fpc, m_ipc;
  bit          m_inf;

  initial begin
    // rst stall redir spur rpc | req mem_pc ov out_pc occ
    add(0,0,0,1,0,      0,0,0,0,0);
    add(0,0,0,1,0,      0,0,0,0,0);
    add(1,0,0,0,0,      1,0,0,0,0);
    add(1,0,0,0,0,      1,16,0,0,0);
    add(1,0,0,0,0,      1,32,1,0,1);
    add(1,0,0,0,0,      1,48,1,16,1);
    add(1,0,0,0,0,      1,64,1,32,1);
    add(1,1,0,0,0,      1,80,1,48,1);
    add(1,1,0,0,0,      1,96,1,48,2);
    add(1,1,0,0,0,      0,112,1,48,3);
    add(1,1,0,1,0,      0,112,1,48,4);
    add(1,0,0,1,0,      0,112,1,48,4);
    add(1,0,0,0,0,      1,112,1,64,3);
    add(1,0,0,0,0,      1,128,1,80,2);
    add(1,0,0,0,0,      1,144,1,96,2);
    add(1,0,0,0,0,      1,160,1,112,2);
    add(1,0,1,0,'h200,  0,176,0,0,2);
    add(1,0,0,0,0,      1,'h200,0,0,0);
    add(1,0,0,0,0,      1,'h210,0,0,0);
    add(1,0,0,0,0,      1,'h220,1,'h200,1);
    add(1,1,0,0,0,      1,'h230,1,'h210,1);
    add(1,1,0,0,0,      1,'h240,1,'h210,2);
    add(1,1,0,0,0,      0,'h250,1,'h210,3);
    add(1,1,1,0,'h300,  0,'h250,0,0,4);
    add(1,1,0,0,0,      1,'h300,0,0,0);
    add(1,1,0,0,0,      1,'h310,0,0,0);
    add(1,0,0,0,0,      1,'h320,1,'h300,1);
    add(1,0,1,0,'h400,  0,'h330,0,0,1);
    add(1,0,1,0,'h500,  0,'h400,0,0,0);
    add(1,0,0,0,0,      1,'h500,0,0,0);
    add(1,0,0,0,0,      1,'h510,0,0,0);
    add(1,0,0,0,0,      1,'h520,1,'h500,1);
    add(0,0,0,0,0,      0,0,0,0,0);
    add(1,0,0,1,0,      1,0,0,0,0);
    add(1,0,0,0,0,      1,16,0,0,0);
    add(1,0,0,0,0,      1,32,1,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].spur, tbl[i].rpc);
      chk($sformatf("tbl[%0d].mem_req", i), req1, tbl[i].e_req);
      chk($sformatf("tbl[%0d].mem_pc", i), mpc1, tbl[i].e_mpc);
      chk($sformatf("tbl[%0d].out_valid", i), ov1, tbl[i].e_ov);
      chk($sformatf("tbl[%0d].occupancy", i), occ1, tbl[i].e_occ);
      if (tbl[i].e_ov || !tbl[i].rst) begin
        chk($sformatf("tbl[%0d].out_pc", i), opc1, tbl[i].e_opc);
        chk($sformatf("tbl[%0d].out_bundle", i), ob1,
            tbl[i].rst ? bnd(tbl[i].e_opc) : 128'd0);
      end
    end

    // Randomized run against a queue-based model of the fetch stage.
    for (int c = 0; c < 2000; c++) begin
      logic r, s, rd, sp, e_req, e_ov;
      logic [31:0] p;
      r  = (c < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
      s  = ($urandom_range(0, 99) < 40);
      rd = ($urandom_range(0, 99) < 8);
      sp = ($urandom_range(0, 99) < 10);
      p  = $urandom;
      drive(r, s, rd, sp, p);
      if (!r) begin
        mq.delete();
        m_fpc = '0;
        m_ipc = '0;
        m_inf = 1'b0;
      end
      e_req = r && !rd && (mq.size() + int'(m_inf) < 4);
      e_ov  = r && !rd && (mq.size() != 0);
      chk($sformatf("rnd[%0d].mem_req", c), req1, e_req);
      chk($sformatf("rnd[%0d].mem_pc", c), mpc1, m_fpc);
      chk($sformatf("rnd[%0d].out_valid", c), ov1, e_ov);
      chk($sformatf("rnd[%0d].occupancy", c), occ1, mq.size());
      if (e_ov) begin
        chk($sformatf("rnd[%0d].out_pc", c), opc1, mq[0]);
        chk($sformatf("rnd[%0d].out_bundle", c), ob1, bnd(mq[0]));
      end
      if (r) begin
        if (rd) begin
          mq.delete();
          m_fpc = p;
          m_inf = 1'b0;
        end else begin
          if (e_ov && !s) void'(mq.pop_front());
          if (m_inf) mq.push_back(m_ipc);
          if (e_req) begin
            m_ipc = m_fpc;
            m_fpc = m_fpc + 32'd16;
          end
          m_inf = e_req;
        end
      end
    end

    // PC wrap from the top of the address space.
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("wrap.rst_req", req2, 1'b0);
    chk("wrap.rst_pc", mpc2, 32'hFFFF_FFF0);
    chk("wrap.rst_ov", ov2, 1'b0);
    chk("wrap.rst_occ", occ2, 3'd0);
    chk("wrap.rst_out_pc", opc2, 32'd0);
    drive(1, 0, 0, 0, 0);
    chk("wrap.req0", req2, 1'b1);
    chk("wrap.pc0", mpc2, 32'hFFFF_FFF0);
    drive(1, 0, 0, 0, 0);
    chk("wrap.pc1", mpc2, 32'h0000_0000);
    chk("wrap.ov1", ov2, 1'b0);
    drive(1, 0, 0, 0, 0);
    chk("wrap.ov2", ov2, 1'b1);
    chk("wrap.out_pc2", opc2, 32'hFFFF_FFF0);
    chk("wrap.out_bundle2", ob2, bnd(32'hFFFF_FFF0));
    drive(1, 0, 0, 0, 0);
    chk("wrap.ov3", ov2, 1'b1);
    chk("wrap.out_pc3", opc2, 32'h0000_0000);
    chk("wrap.out_bundle3", ob2, bnd(32'h0000_0000));
    chk("wrap.mem_pc3", mpc2, 32'h0000_0020);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
